// File: rtl/sha_sched_pkg.sv
// Shared types for the SHA-256 nonce scheduler: FSM states, default widths and
// the per-core result record.
package sha_sched_pkg;

   localparam int NONCE_W_DEF = 16;
   localparam int ADDR_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [31:0] tag;
      logic [31:0] data;
   } result_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [N-1:0] rot;
   logic [N-1:0] rot_gnt;

   // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
   assign rot     = N'({req, req} >> ptr);
   assign rot_gnt = rot & (~rot + N'(1));
   assign grant   = N'({rot_gnt, rot_gnt} >> (N - int'(ptr)));

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Issues nonces round-robin to a pool of hash cores and serialises their
// results onto the single result-memory write port at output_addr+nonce.
module sha_nonce_scheduler
   import sha_sched_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = NONCE_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      output_addr,
   input  logic [NONCE_W-1:0]     num_nonces,
   output logic                   done,
   output logic [NUM_CORES-1:0]   core_start,
   output logic [31:0]            core_nonce,
   input  logic [NUM_CORES-1:0]   core_done,
   input  logic [32*NUM_CORES-1:0] core_result,
   output logic                   mem_clk,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [31:0]            mem_write_data
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   state_t               state, state_n;
   logic [ADDR_W-1:0]    base;
   logic [NONCE_W-1:0]   count, next_nonce, written;
   logic [NUM_CORES-1:0] inflight, pending;
   logic [NUM_CORES-1:0] iss_req, iss_grant, wr_grant, collect;
   logic [PW-1:0]        iss_ptr, wr_ptr, iss_ptr_n, wr_ptr_n;
   result_rec_t          recs [NUM_CORES];
   result_rec_t          wr_rec;
   logic                 accept, issue, wr_en;
   logic                 unused_tag;

   assign mem_clk    = clk;
   assign done       = (state == DONE);
   assign accept     = start && ((state == IDLE) || (state == DONE));
   assign iss_req    = ~inflight & ~pending;
   assign issue      = (state == RUN) && (iss_req != '0);
   assign wr_en      = (pending != '0);
   assign collect    = core_done & inflight;
   assign unused_tag = ^wr_rec.tag;

   rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_issue_arb (
      .req   (iss_req),
      .ptr   (iss_ptr),
      .grant (iss_grant)
   );

   rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_write_arb (
      .req   (pending),
      .ptr   (wr_ptr),
      .grant (wr_grant)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (accept) state_n = (num_nonces == '0) ? DONE : RUN;
         RUN:        if (issue && (next_nonce + NONCE_W'(1) == count)) state_n = DRAIN;
         DRAIN:      if (written == count) state_n = DONE;
         default:    state_n = IDLE;
      endcase
   end

   always_comb begin
      iss_ptr_n = iss_ptr;
      wr_ptr_n  = wr_ptr;
      wr_rec    = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (iss_grant[i]) iss_ptr_n = PW'((i + 1) % NUM_CORES);
         if (wr_grant[i]) begin
            wr_ptr_n = PW'((i + 1) % NUM_CORES);
            wr_rec   = recs[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base           <= '0;
         count          <= '0;
         next_nonce     <= '0;
         written        <= '0;
         inflight       <= '0;
         pending        <= '0;
         iss_ptr        <= '0;
         wr_ptr         <= '0;
         core_start     <= '0;
         core_nonce     <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++) recs[i] <= '0;
      end else begin
         core_start <= '0;
         mem_we     <= 1'b0;
         if (accept) begin
            base       <= output_addr;
            count      <= num_nonces;
            next_nonce <= '0;
            written    <= '0;
         end
         if (issue) begin
            core_start <= iss_grant;
            core_nonce <= 32'(next_nonce);
            next_nonce <= next_nonce + NONCE_W'(1);
            iss_ptr    <= iss_ptr_n;
         end
         // A core can only be issued when idle and only collected when in flight,
         // so set/clear terms never target the same core in one cycle.
         inflight <= (inflight & ~collect) | (issue ? iss_grant : '0);
         pending  <= (pending | collect) & ~(wr_en ? wr_grant : '0);
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (issue && iss_grant[i]) recs[i].tag <= 32'(next_nonce);
            if (collect[i]) recs[i].data <= core_result[32*i +: 32];
         end
         if (wr_en) begin
            mem_we         <= 1'b1;
            mem_addr       <= base + ADDR_W'(wr_rec.tag);
            mem_write_data <= wr_rec.data;
            written        <= written + NONCE_W'(1);
            wr_ptr         <= wr_ptr_n;
         end
      end
   end

   a_done_needs_inflight: assert property (
      @(posedge clk) disable iff (reset) (core_done & ~inflight) == '0
   );

endmodule
